// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle CPU datapath: one state per clock through
// fetch/decode/execute/memory/writeback, with memory-ready stalls and a retire counter.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        ir_wr,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        ALU_src_a,
  output logic [1:0]  ALU_src_b,
  output logic [2:0]  ALU_ctrl,
  output logic        zero_ext,
  output logic        instr_done,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_XORI  = 6'h0e, OP_LW   = 6'h23, OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2a;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_XOR = 3'b010,
                         ALU_SLT = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'b00;
    wb_src     = 2'b00;
    ALU_src_a  = 1'b0;
    ALU_src_b  = 2'b00;
    ALU_ctrl   = ALU_ADD;
    zero_ext   = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALU_src_b = 2'b01;
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALU_src_b = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) state_d = S_EXEC_R;
            else if (funct == FN_JR)                                    state_d = S_JR;
            else                                                        state_d = S_HALT;
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ALU_src_a = 1'b1;
        if (funct == FN_SUB)      ALU_ctrl = ALU_SUB;
        else if (funct == FN_SLT) ALU_ctrl = ALU_SLT;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_wr     = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        ALU_src_a = 1'b1;
        ALU_src_b = 2'b10;
        if (opcode == OP_XORI) begin
          ALU_ctrl = ALU_XOR;
          zero_ext = 1'b1;
        end
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALU_src_a = 1'b1;
        ALU_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        wb_src     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_wr     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALU_src_a  = 1'b1;
        ALU_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        pc_wr      = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP, S_JAL: begin
        pc_wr      = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        if (state_q == S_JAL) begin
          reg_wr  = 1'b1;
          reg_dst = 2'b10;
          wb_src  = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_wr      = 1'b1;
        pc_src     = 2'b11;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Reset kills every side effect of the current cycle, including a pending store.
    if (reset) begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign retired_d = retired_q + {31'b0, instr_done};
  assign retired   = retired_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle CPU. It steps the shared datapath through fetch, decode, execute, memory and writeback, one state per clock. The datapath is one ALU, one unified instruction/data memory port, the register file, and the IR/A/B/ALUout/MDR holding registers. It consumes the opcode/funct fields produced by the instruction decoder and the ALU zero flag, and waits on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU zero flag, valid in the cycle the ALU operates
- mem_ready  in  1  memory completes the current access this cycle
- pc_wr  out  1  load PC this edge
- pc_src  out  2  00 ALU result, 01 ALUout (branch target), 10 {PC[31:28],target,2'b00}, 11 A reg (rs)
- iord  out  1  memory address select: 0 PC, 1 ALUout
- ir_wr  out  1  load IR from memory read data
- mem_wr  out  1  memory write strobe
- reg_wr  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- wb_src  out  2  00 ALUout, 01 MDR, 10 PC
- ALU_src_a  out  1  0 PC, 1 A reg
- ALU_src_b  out  2  00 B reg, 01 constant 4, 10 extended imm16, 11 sign-extended imm16<<2
- ALU_ctrl  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- zero_ext  out  1  1 selects zero-extension of imm16 (XORI only)
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- halted  out  1  sticky illegal-instruction flag
- retired  out  32  count of completed instructions

## Operation
- Supported: R-type ADD(20) SUB(22) SLT(2a) JR(08); LW(23), SW(2b), BEQ(04), BNE(05), ADDI(08), XORI(0e), J(02), JAL(03). Values are hex.
- All outputs are 0 / ADD unless listed for the state.
- FETCH: iord=0, ALU_src_a=0, ALU_src_b=01, ADD.
  - ir_wr=pc_wr=mem_ready, pc_src=00.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE: ALU_src_a=0, ALU_src_b=11, ADD (branch target into ALUout). Next state by opcode:
  - R-type with ADD/SUB/SLT goes to EXEC_R.
  - R-type with JR goes to JR.
  - LW/SW go to MEM_ADDR.
  - BEQ/BNE go to BRANCH.
  - ADDI/XORI go to EXEC_I.
  - J goes to JUMP; JAL goes to JAL.
  - Anything else goes to HALT.
- EXEC_R: ALU_src_a=1, ALU_src_b=00, ALU_ctrl from funct. Next WB_R.
- WB_R: reg_wr=1, reg_dst=01, wb_src=00, instr_done. Next FETCH.
- EXEC_I: ALU_src_a=1, ALU_src_b=10.
  - ADDI: ADD, zero_ext=0. XORI: XOR, zero_ext=1.
  - Next WB_I.
- WB_I: reg_wr=1, reg_dst=00, wb_src=00, instr_done. Next FETCH.
- MEM_ADDR: ALU_src_a=1, ALU_src_b=10, ADD. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: iord=1. Holds until mem_ready, then WB_MEM.
- WB_MEM: reg_wr=1, reg_dst=00, wb_src=01, instr_done. Next FETCH.
- MEM_WR: iord=1, mem_wr=1, held until mem_ready. instr_done in the mem_ready cycle. Next FETCH.
- BRANCH: ALU_src_a=1, ALU_src_b=00, SUB, pc_src=01, instr_done.
  - pc_wr=zero for BEQ, ~zero for BNE. Next FETCH.
- JUMP: pc_wr=1, pc_src=10, instr_done. Next FETCH.
- JAL: same as JUMP, plus reg_wr=1, reg_dst=10, wb_src=10. The PC already holds PC+4 at this point.
- JR: pc_wr=1, pc_src=11, instr_done. Next FETCH.
- HALT: all enables 0, halted=1. Exit only by reset.
- retired increments on every instr_done and wraps from FFFFFFFF to 0.

## Timing
- Outputs are combinational from the state register plus opcode/funct/zero/mem_ready. There are no output registers.
- While reset=1, all enables and instr_done are forced to 0.
- At the reset edge: state=FETCH, retired=0, halted=0.
- Reset has priority over every other event, including mid-instruction and mid-wait. An in-flight SW is abandoned because mem_wr drops in the reset cycle.
- Cycles per instruction with mem_ready=1:
  - R-type/ADDI/XORI/SW: 4
  - LW: 5
  - BEQ/BNE/J/JAL/JR: 3
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle. mem_ready is ignored in all other states.
- instr_done and the retired increment occur in the same cycle; the retired update is visible after that edge.
- Entry into HALT does not pulse instr_done.

## Test plan
- Reset, then ADD ($3,$1,$2) with mem_ready=1:
  - FETCH→DECODE→EXEC_R→WB_R.
  - ALU_ctrl=000 in EXEC_R; reg_wr=1, reg_dst=01 in cycle 4.
  - retired=1.
- LW with mem_ready low for 3 cycles in MEM_RD:
  - 8 cycles total; iord=1 throughout MEM_RD.
  - WB_MEM has wb_src=01, reg_dst=00.
- BEQ with zero=1 → pc_wr=1, pc_src=01 in cycle 3. BNE with zero=1 → pc_wr=0. Both retire.
- JAL:
  - Cycle 3 has pc_wr=1, pc_src=10, reg_wr=1, reg_dst=10, wb_src=10.
  - Then JR: pc_src=11.
- Opcode 3f:
  - HALT after DECODE, halted=1, no enables, retired unchanged for 20 cycles.
  - reset clears halted and state returns to FETCH.
- Reset asserted during MEM_WR with mem_ready=0:
  - mem_wr=0 in the reset cycle.
  - FETCH, retired=0 next cycle.
  - Preload retired=FFFFFFFF via 2^32-1 retirements (or force), then one retirement → 0.
